adc_scan_scheduler: RTL and testbench

- Shares one dual-slope ADC (control machine plus counter) among N_CH analog inputs through an external analog mux.
- Walks the enabled channels in round-robin order. For each channel it drives the mux select, waits a settle time, pulses the conversion start, waits for completion with a timeout, then presents the count on a valid/ready result port.
- Sits between the ADC control machine and the system-side consumer (display/UART).

---
 rtl/adc_scan_scheduler.sv | 169 ++++++++++++++++
 tb/tb_adc_scan_scheduler.sv | 296 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/adc_scan_scheduler.sv
// Round-robin scheduler sharing one dual-slope ADC across N_CH mux inputs:
// settle, start, wait with timeout, then hand the count out on valid/ready.
module adc_scan_scheduler #(
   parameter int N_CH        = 4,
   parameter int SEL_W       = 2,
   parameter int CNT_W       = 12,
   parameter int SETTLE_CYC  = 16,
   parameter int TIMEOUT_CYC = 16384
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             scan_en,
   input  logic             single_shot,
   input  logic [N_CH-1:0]  ch_mask,
   output logic [SEL_W-1:0] mux_sel,
   output logic             adc_start,
   input  logic             adc_done,
   input  logic [CNT_W-1:0] adc_count,
   output logic             result_valid,
   input  logic             result_ready,
   output logic [CNT_W-1:0] result_data,
   output logic [SEL_W-1:0] result_ch,
   output logic             result_err,
   output logic             busy,
   output logic             scan_done
);

   // state    | meaning
   // S_IDLE   | waiting for scan_en / single_shot with a non-empty mask
   // S_SETTLE | mux_sel driven, counting down the analog settle time
   // S_START  | one-cycle adc_start pulse, timeout counter loaded
   // S_WAIT   | waiting for adc_done or timeout
   // S_OUTPUT | result presented, held until result_ready
   // S_NEXT   | advance to the next enabled channel or close the pass
   typedef enum logic [2:0] {
      S_IDLE, S_SETTLE, S_START, S_WAIT, S_OUTPUT, S_NEXT
   } state_t;

   localparam int TMR_MAX = (TIMEOUT_CYC > SETTLE_CYC) ? TIMEOUT_CYC : SETTLE_CYC;
   localparam int TMR_W   = $clog2(TMR_MAX + 1);
   localparam logic [TMR_W-1:0] SETTLE_LD = TMR_W'(SETTLE_CYC);
   localparam logic [TMR_W-1:0] TMO_LD    = TMR_W'(TIMEOUT_CYC);
   localparam logic [TMR_W-1:0] TMR_ONE   = TMR_W'(1);

   state_t            state, state_nxt;
   logic [TMR_W-1:0]  tmr, tmr_nxt;
   logic [N_CH-1:0]   scan_mask, mask_nxt;
   logic              cont_mode, cont_nxt;
   logic [SEL_W-1:0]  sel_nxt;
   logic [CNT_W-1:0]  data_nxt;
   logic [SEL_W-1:0]  rch_nxt;
   logic              err_nxt;
   logic              nxt_found;
   logic [SEL_W-1:0]  nxt_idx;

   function automatic logic [SEL_W-1:0] lowest_set(input logic [N_CH-1:0] m);
      lowest_set = '0;
      for (int i = N_CH - 1; i >= 0; i--)
         if (m[i]) lowest_set = SEL_W'(i);
   endfunction

   // next enabled channel strictly above the one just converted
   always_comb begin
      nxt_found = 1'b0;
      nxt_idx   = '0;
      for (int i = N_CH - 1; i >= 0; i--) begin
         if (scan_mask[i] && (i > int'(mux_sel))) begin
            nxt_found = 1'b1;
            nxt_idx   = SEL_W'(i);
         end
      end
   end

   always_comb begin
      state_nxt    = state;
      tmr_nxt      = tmr;
      mask_nxt     = scan_mask;
      cont_nxt     = cont_mode;
      sel_nxt      = mux_sel;
      data_nxt     = result_data;
      rch_nxt      = result_ch;
      err_nxt      = result_err;
      adc_start    = 1'b0;
      result_valid = 1'b0;
      scan_done    = 1'b0;
      busy         = (state != S_IDLE);
      case (state)
         S_IDLE: begin
            if ((scan_en || single_shot) && (ch_mask != '0)) begin
               mask_nxt  = ch_mask;
               cont_nxt  = scan_en;
               sel_nxt   = lowest_set(ch_mask);
               tmr_nxt   = SETTLE_LD;
               state_nxt = S_SETTLE;
            end
         end
         S_SETTLE: begin
            if (tmr <= TMR_ONE) state_nxt = S_START;
            else                tmr_nxt   = tmr - TMR_ONE;
         end
         S_START: begin
            adc_start = 1'b1;
            tmr_nxt   = TMO_LD;
            state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (adc_done) begin
               data_nxt  = adc_count;
               rch_nxt   = mux_sel;
               err_nxt   = 1'b0;
               state_nxt = S_OUTPUT;
            end else if (tmr <= TMR_ONE) begin
               data_nxt  = '0;
               rch_nxt   = mux_sel;
               err_nxt   = 1'b1;
               state_nxt = S_OUTPUT;
            end else begin
               tmr_nxt = tmr - TMR_ONE;
            end
         end
         S_OUTPUT: begin
            result_valid = 1'b1;
            if (result_ready) state_nxt = S_NEXT;
         end
         S_NEXT: begin
            if (nxt_found) begin
               sel_nxt   = nxt_idx;
               tmr_nxt   = SETTLE_LD;
               state_nxt = S_SETTLE;
            end else begin
               scan_done = 1'b1;
               // continuous mode re-samples the mask only at the pass boundary
               if (cont_mode && scan_en && (ch_mask != '0)) begin
                  mask_nxt  = ch_mask;
                  sel_nxt   = lowest_set(ch_mask);
                  tmr_nxt   = SETTLE_LD;
                  state_nxt = S_SETTLE;
               end else begin
                  state_nxt = S_IDLE;
               end
            end
         end
         default: state_nxt = S_IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state       <= S_IDLE;
         tmr         <= '0;
         scan_mask   <= '0;
         cont_mode   <= 1'b0;
         mux_sel     <= '0;
         result_data <= '0;
         result_ch   <= '0;
         result_err  <= 1'b0;
      end else begin
         state       <= state_nxt;
         tmr         <= tmr_nxt;
         scan_mask   <= mask_nxt;
         cont_mode   <= cont_nxt;
         mux_sel     <= sel_nxt;
         result_data <= data_nxt;
         result_ch   <= rch_nxt;
         result_err  <= err_nxt;
      end
   end

endmodule

// File: tb/tb_adc_scan_scheduler.sv
// Self-checking bench for adc_scan_scheduler: ADC responder model plus a
// mask-to-channel-order reference, randomized passes and directed corner cases.
module tb_adc_scan_scheduler;
   localparam int N_CH        = 4;
   localparam int SEL_W       = 2;
   localparam int CNT_W       = 12;
   localparam int SETTLE_CYC  = 16;
   localparam int TIMEOUT_CYC = 512;
   localparam int BUDGET      = TIMEOUT_CYC + SETTLE_CYC + 400;

   logic             clk = 1'b0;
   logic             reset_n = 1'b0;
   logic             scan_en = 1'b0;
   logic             single_shot = 1'b0;
   logic [N_CH-1:0]  ch_mask = '0;
   logic [SEL_W-1:0] mux_sel;
   logic             adc_start;
   logic             adc_done = 1'b0;
   logic [CNT_W-1:0] adc_count = '0;
   logic             result_valid;
   logic             result_ready = 1'b0;
   logic [CNT_W-1:0] result_data;
   logic [SEL_W-1:0] result_ch;
   logic             result_err;
   logic             busy;
   logic             scan_done;

   int n_checks = 0;
   int n_fail   = 0;

   adc_scan_scheduler #(
      .N_CH(N_CH), .SEL_W(SEL_W), .CNT_W(CNT_W),
      .SETTLE_CYC(SETTLE_CYC), .TIMEOUT_CYC(TIMEOUT_CYC)
   ) dut (
      .clk(clk), .reset_n(reset_n), .scan_en(scan_en), .single_shot(single_shot),
      .ch_mask(ch_mask), .mux_sel(mux_sel), .adc_start(adc_start),
      .adc_done(adc_done), .adc_count(adc_count), .result_valid(result_valid),
      .result_ready(result_ready), .result_data(result_data), .result_ch(result_ch),
      .result_err(result_err), .busy(busy), .scan_done(scan_done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ADC responder: answers adc_start with adc_done after adc_delay cycles
   int               adc_delay = 100;
   bit               adc_respond = 1'b1;
   logic [CNT_W-1:0] ch_count [N_CH];
   int               adc_timer = 0;
   bit               adc_pend = 1'b0;
   logic [SEL_W-1:0] conv_ch = '0;
   always @(posedge clk) begin
      adc_done <= 1'b0;
      if (!reset_n) adc_pend <= 1'b0;
      else if (adc_start && adc_respond) begin
         adc_pend  <= 1'b1;
         adc_timer <= adc_delay;
         conv_ch   <= mux_sel;
      end else if (adc_pend) begin
         if (adc_timer <= 1) begin
            adc_done  <= 1'b1;
            adc_count <= ch_count[conv_ch];
            adc_pend  <= 1'b0;
         end else adc_timer <= adc_timer - 1;
      end
   end

   // event monitor
   int start_cnt = 0, done_cnt = 0, dbl_start = 0;
   int last_start_cyc = 0, last_done_cyc = 0, sel_evt_cyc = 0;
   int settle_q[$];
   logic prev_start = 1'b0, prev_busy = 1'b0;
   logic [SEL_W-1:0] prev_sel = '0;
   always @(negedge clk) begin
      if ((mux_sel != prev_sel) || (busy && !prev_busy)) sel_evt_cyc = cyc;
      if (adc_start) begin
         start_cnt++;
         last_start_cyc = cyc;
         settle_q.push_back(cyc - sel_evt_cyc);
         if (prev_start) dbl_start++;
      end
      if (adc_done) last_done_cyc = cyc;
      if (scan_done) done_cnt++;
      prev_start = adc_start;
      prev_busy  = busy;
      prev_sel   = mux_sel;
   end

   // reference: a pass converts the enabled channels in ascending order
   int exp_q[$];
   function automatic void build_exp(input logic [N_CH-1:0] m);
      exp_q.delete();
      for (int c = 0; c < N_CH; c++) if (m[c]) exp_q.push_back(c);
   endfunction

   task automatic get_result(input int ready_dly, output logic [SEL_W-1:0] ch,
                             output logic [CNT_W-1:0] data, output logic err,
                             output bit ok, output int t_valid);
      int n = 0;
      ok = 1'b0; ch = '0; data = '0; err = 1'b0; t_valid = 0;
      while (!result_valid && n < BUDGET) begin @(negedge clk); n++; end
      if (!result_valid) return;
      t_valid = cyc;
      ch = result_ch; data = result_data; err = result_err; ok = 1'b1;
      repeat (ready_dly) @(negedge clk);
      result_ready = 1'b1;
      @(negedge clk);
      result_ready = 1'b0;
   endtask

   task automatic pulse_single(input logic [N_CH-1:0] m);
      ch_mask = m;
      single_shot = 1'b1;
      @(negedge clk);
      single_shot = 1'b0;
   endtask

   task automatic wait_idle();
      int n = 0;
      while (busy && n < 60) begin @(negedge clk); n++; end
      repeat (2) @(negedge clk);
   endtask

   task automatic test_reset();
      reset_n = 1'b0;
      repeat (3) @(negedge clk);
      n_checks++; if (mux_sel !== '0) begin n_fail++; $display("FAIL reset_mux_sel got=%0h exp=0", mux_sel); end
      n_checks++; if ({adc_start, result_valid, scan_done} !== 3'b000) begin n_fail++; $display("FAIL reset_pulses got=%b exp=000", {adc_start, result_valid, scan_done}); end
      n_checks++; if ({result_data, result_ch, result_err} !== '0) begin n_fail++; $display("FAIL reset_result got=%0h/%0h/%0b exp=0", result_data, result_ch, result_err); end
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy got=%b exp=0", busy); end
      reset_n = 1'b1;
      @(negedge clk);
   endtask

   task automatic test_single_pass();
      logic [SEL_W-1:0] ch; logic [CNT_W-1:0] data; logic err; bit ok; int tv;
      int d0, s0;
      ch_count[0] = 12'h111; ch_count[1] = 12'h222; ch_count[2] = 12'h0AA; ch_count[3] = 12'h333;
      adc_delay = 100; adc_respond = 1'b1;
      settle_q.delete(); d0 = done_cnt; s0 = start_cnt;
      pulse_single(4'b1011);
      build_exp(4'b1011);
      foreach (exp_q[i]) begin
         get_result(0, ch, data, err, ok, tv);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL single_timeout idx=%0d got=no_valid exp=valid", i); end
         n_checks++; if (ch !== SEL_W'(exp_q[i])) begin n_fail++; $display("FAIL single_ch idx=%0d got=%0d exp=%0d", i, ch, exp_q[i]); end
         n_checks++; if (data !== ch_count[exp_q[i]]) begin n_fail++; $display("FAIL single_data idx=%0d got=%0h exp=%0h", i, data, ch_count[exp_q[i]]); end
         n_checks++; if (err !== 1'b0) begin n_fail++; $display("FAIL single_err idx=%0d got=%b exp=0", i, err); end
         n_checks++; if (tv - last_done_cyc !== 1) begin n_fail++; $display("FAIL single_done_lat idx=%0d got=%0d exp=1", i, tv - last_done_cyc); end
      end
      wait_idle();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL single_idle got=%b exp=0", busy); end
      n_checks++; if (done_cnt - d0 !== 1) begin n_fail++; $display("FAIL single_scan_done got=%0d exp=1", done_cnt - d0); end
      n_checks++; if (start_cnt - s0 !== 3) begin n_fail++; $display("FAIL single_starts got=%0d exp=3", start_cnt - s0); end
      n_checks++; if (settle_q.size() !== 3) begin n_fail++; $display("FAIL settle_count got=%0d exp=3", settle_q.size()); end
      foreach (settle_q[i]) begin
         n_checks++; if (settle_q[i] !== SETTLE_CYC) begin n_fail++; $display("FAIL settle_delay idx=%0d got=%0d exp=%0d", i, settle_q[i], SETTLE_CYC); end
      end
      n_checks++; if (dbl_start !== 0) begin n_fail++; $display("FAIL start_width got=%0d exp=0 multi-cycle pulses", dbl_start); end
   endtask

   task automatic test_timeout();
      logic [SEL_W-1:0] ch; logic [CNT_W-1:0] data; logic err; bit ok; int tv;
      adc_respond = 1'b0;
      pulse_single(4'b0101);
      build_exp(4'b0101);
      foreach (exp_q[i]) begin
         get_result(0, ch, data, err, ok, tv);
         n_checks++; if (!ok) begin n_fail++; $display("FAIL tmo_valid idx=%0d got=no_valid exp=valid", i); end
         n_checks++; if ({ch, data, err} !== {SEL_W'(exp_q[i]), {CNT_W{1'b0}}, 1'b1}) begin n_fail++; $display("FAIL tmo_result idx=%0d got=ch%0d/%0h/%b exp=ch%0d/0/1", i, ch, data, err, exp_q[i]); end
         n_checks++; if (tv - last_start_cyc !== TIMEOUT_CYC + 1) begin n_fail++; $display("FAIL tmo_latency idx=%0d got=%0d exp=%0d", i, tv - last_start_cyc, TIMEOUT_CYC + 1); end
      end
      wait_idle();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL tmo_idle got=%b exp=0", busy); end
      adc_respond = 1'b1;
   endtask

   task automatic test_backpressure();
      logic [SEL_W-1:0] cch; logic [CNT_W-1:0] cdata; logic cerr;
      int n = 0, s0;
      ch_count[1] = 12'h5A7; adc_delay = 40;
      pulse_single(4'b0010);
      while (!result_valid && n < BUDGET) begin @(negedge clk); n++; end
      cch = result_ch; cdata = result_data; cerr = result_err; s0 = start_cnt;
      n_checks++; if ({result_valid, cch, cdata, cerr} !== {1'b1, 2'd1, 12'h5A7, 1'b0}) begin n_fail++; $display("FAIL bp_first got=%b/%0d/%0h/%b exp=1/1/5a7/0", result_valid, cch, cdata, cerr); end
      for (int k = 0; k < 50; k++) begin
         @(negedge clk);
         n_checks++; if ({result_valid, result_ch, result_data, result_err, adc_start} !== {1'b1, cch, cdata, cerr, 1'b0}) begin
            n_fail++; $display("FAIL bp_hold cyc=%0d got=%b/%0d/%0h/%b/%b exp=1/%0d/%0h/%b/0", k, result_valid, result_ch, result_data, result_err, adc_start, cch, cdata, cerr);
         end
      end
      n_checks++; if (start_cnt !== s0) begin n_fail++; $display("FAIL bp_no_start got=%0d exp=%0d", start_cnt, s0); end
      result_ready = 1'b1; @(negedge clk); result_ready = 1'b0;
      n_checks++; if (result_valid !== 1'b0) begin n_fail++; $display("FAIL bp_release got=%b exp=0", result_valid); end
      wait_idle();
   endtask

   task automatic test_continuous();
      logic [SEL_W-1:0] ch; logic [CNT_W-1:0] data; logic err; bit ok; int tv;
      int d0, s0;
      ch_count[0] = 12'h0C0; ch_count[1] = 12'h0C1; ch_count[2] = 12'h0C2;
      adc_delay = 30; d0 = done_cnt; s0 = start_cnt;
      ch_mask = 4'b0001; scan_en = 1'b1; single_shot = 1'b1;
      @(negedge clk);
      single_shot = 1'b0;
      ch_mask = 4'b0110;
      get_result(0, ch, data, err, ok, tv);
      n_checks++; if ({ok, ch, data} !== {1'b1, 2'd0, 12'h0C0}) begin n_fail++; $display("FAIL cont_r0 got=%b/%0d/%0h exp=1/0/0c0", ok, ch, data); end
      get_result(2, ch, data, err, ok, tv);
      n_checks++; if ({ok, ch, data} !== {1'b1, 2'd1, 12'h0C1}) begin n_fail++; $display("FAIL cont_r1 got=%b/%0d/%0h exp=1/1/0c1", ok, ch, data); end
      scan_en = 1'b0;
      get_result(1, ch, data, err, ok, tv);
      n_checks++; if ({ok, ch, data} !== {1'b1, 2'd2, 12'h0C2}) begin n_fail++; $display("FAIL cont_r2 got=%b/%0d/%0h exp=1/2/0c2", ok, ch, data); end
      wait_idle();
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cont_idle got=%b exp=0", busy); end
      n_checks++; if (done_cnt - d0 !== 2) begin n_fail++; $display("FAIL cont_scan_done got=%0d exp=2", done_cnt - d0); end
      n_checks++; if (start_cnt - s0 !== 3) begin n_fail++; $display("FAIL cont_starts got=%0d exp=3", start_cnt - s0); end
   endtask

   task automatic test_reset_midpass();
      int n, s0, d0;
      adc_delay = 100;
      s0 = start_cnt; n = 0;
      pulse_single(4'b0001);
      while (start_cnt == s0 && n < BUDGET) begin @(negedge clk); n++; end
      repeat (5) @(negedge clk);
      d0 = done_cnt;
      reset_n = 1'b0; @(negedge clk);
      n_checks++; if ({mux_sel, adc_start, result_valid, result_data, result_ch, result_err, busy, scan_done} !== '0) begin
         n_fail++; $display("FAIL rst_wait got=%b/%b/%b/%0h/%0d/%b/%b/%b exp=all0", mux_sel, adc_start, result_valid, result_data, result_ch, result_err, busy, scan_done);
      end
      reset_n = 1'b1; @(negedge clk);
      n = 0;
      pulse_single(4'b1000);
      while (!result_valid && n < BUDGET) begin @(negedge clk); n++; end
      n_checks++; if (result_valid !== 1'b1) begin n_fail++; $display("FAIL rst_reach_output got=%b exp=1", result_valid); end
      reset_n = 1'b0; @(negedge clk);
      n_checks++; if ({mux_sel, adc_start, result_valid, result_data, result_ch, result_err, busy, scan_done} !== '0) begin
         n_fail++; $display("FAIL rst_output got=%b/%b/%b/%0h/%0d/%b/%b/%b exp=all0", mux_sel, adc_start, result_valid, result_data, result_ch, result_err, busy, scan_done);
      end
      reset_n = 1'b1; @(negedge clk);
      n_checks++; if (done_cnt !== d0) begin n_fail++; $display("FAIL rst_no_scan_done got=%0d exp=%0d", done_cnt, d0); end
      s0 = start_cnt;
      pulse_single(4'b0000);
      repeat (40) @(negedge clk);
      n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL empty_mask_busy got=%b exp=0", busy); end
      n_checks++; if (start_cnt !== s0) begin n_fail++; $display("FAIL empty_mask_start got=%0d exp=%0d", start_cnt, s0); end
   endtask

   task automatic test_random();
      logic [SEL_W-1:0] ch; logic [CNT_W-1:0] data; logic err; bit ok; int tv;
      logic [N_CH-1:0] m;
      int d0, rdy;
      for (int it = 0; it < 8; it++) begin
         m = N_CH'($urandom_range(0, (1 << N_CH) - 1));
         for (int c = 0; c < N_CH; c++) ch_count[c] = CNT_W'($urandom_range(0, (1 << CNT_W) - 1));
         adc_delay = $urandom_range(20, 120);
         rdy = $urandom_range(0, 6);
         d0 = done_cnt;
         pulse_single(m);
         build_exp(m);
         if (exp_q.size() == 0) begin
            repeat (20) @(negedge clk);
            n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL rand_empty it=%0d got=%b exp=0", it, busy); end
         end else begin
            foreach (exp_q[i]) begin
               get_result(rdy, ch, data, err, ok, tv);
               // mid-pass mask churn and stray single_shot must not disturb the pass
               ch_mask = N_CH'($urandom_range(0, (1 << N_CH) - 1));
               single_shot = 1'b1; @(negedge clk); single_shot = 1'b0;
               n_checks++; if ({ok, ch, data, err} !== {1'b1, SEL_W'(exp_q[i]), ch_count[exp_q[i]], 1'b0}) begin
                  n_fail++; $display("FAIL rand_result it=%0d idx=%0d got=%b/%0d/%0h/%b exp=1/%0d/%0h/0", it, i, ok, ch, data, err, exp_q[i], ch_count[exp_q[i]]);
               end
            end
            wait_idle();
            n_checks++; if ({busy, 32'(done_cnt - d0)} !== {1'b0, 32'd1}) begin n_fail++; $display("FAIL rand_end it=%0d busy=%b scan_done=%0d exp=0/1", it, busy, done_cnt - d0); end
         end
      end
   endtask

   initial begin
      for (int c = 0; c < N_CH; c++) ch_count[c] = '0;
      test_reset();
      test_single_pass();
      test_timeout();
      test_backpressure();
      test_continuous();
      test_reset_midpass();
      test_random();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
